// File: rtl/nonce_uart_tx.sv
// rtl/nonce_uart_tx.sv - serialises a 32-bit word as four 8N1 UART bytes, MSB byte first
module nonce_uart_tx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [31:0] nonceIn,
  input  logic        sendValid,
  output logic        ready,
  output logic        tx,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);

  state_t      state, stateNext;
  logic [15:0] clkCnt, clkCntNext;
  logic [2:0]  bitIdx, bitIdxNext;
  logic [1:0]  byteIdx, byteIdxNext;
  logic [31:0] shiftReg, shiftNext;
  logic [7:0]  curByte;
  logic        txNext, readyNext, doneNext;
  logic        bitEnd, lastStop;

  assign bitEnd   = (clkCnt == 16'd0);
  // The IDLE/done cycle doubles as the final cycle of the 4th stop bit,
  // so a word accepted in the done cycle starts with no gap.
  assign lastStop = (byteIdx == 2'd3) && (clkCnt == 16'd1);

  always_comb begin
    stateNext   = state;
    clkCntNext  = clkCnt;
    bitIdxNext  = bitIdx;
    byteIdxNext = byteIdx;
    shiftNext   = shiftReg;
    doneNext    = 1'b0;
    case (state)
      IDLE: begin
        if (sendValid && ready) begin
          stateNext   = START;
          shiftNext   = nonceIn;
          clkCntNext  = BIT_LAST;
          bitIdxNext  = 3'd0;
          byteIdxNext = 2'd0;
        end
      end
      START: begin
        if (bitEnd) begin
          stateNext  = DATA;
          clkCntNext = BIT_LAST;
        end else begin
          clkCntNext = clkCnt - 16'd1;
        end
      end
      DATA: begin
        if (bitEnd) begin
          clkCntNext = BIT_LAST;
          bitIdxNext = bitIdx + 3'd1;
          if (bitIdx == 3'd7) stateNext = STOP;
        end else begin
          clkCntNext = clkCnt - 16'd1;
        end
      end
      STOP: begin
        if (lastStop) begin
          stateNext   = IDLE;
          doneNext    = 1'b1;
          clkCntNext  = 16'd0;
          bitIdxNext  = 3'd0;
          byteIdxNext = 2'd0;
        end else if (bitEnd) begin
          stateNext   = START;
          clkCntNext  = BIT_LAST;
          byteIdxNext = byteIdx + 2'd1;
          shiftNext   = {shiftReg[23:0], 8'h00};
        end else begin
          clkCntNext = clkCnt - 16'd1;
        end
      end
      default: stateNext = IDLE;
    endcase

    curByte   = shiftNext[31:24];
    readyNext = (stateNext == IDLE);
    case (stateNext)
      START:   txNext = 1'b0;
      DATA:    txNext = curByte[bitIdxNext];
      default: txNext = 1'b1;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      clkCnt   <= 16'd0;
      bitIdx   <= 3'd0;
      byteIdx  <= 2'd0;
      shiftReg <= 32'd0;
      tx       <= 1'b1;
      ready    <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= stateNext;
      clkCnt   <= clkCntNext;
      bitIdx   <= bitIdxNext;
      byteIdx  <= byteIdxNext;
      shiftReg <= shiftNext;
      tx       <= txNext;
      ready    <= readyNext;
      done     <= doneNext;
    end
  end

endmodule

// File: tb/tb_nonce_uart_tx.sv
// tb/tb_nonce_uart_tx.sv - directed checks of nonce_uart_tx at CLKS_PER_BIT 4 and 434
module tb_nonce_uart_tx;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] nonce4 = '0, nonce434 = '0;
  logic        sendValid4 = 1'b0, sendValid434 = 1'b0;
  logic        ready4, tx4, done4, ready434, tx434, done434;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int doneCnt4 = 0;
  int lastDoneCyc = 0;

  always #5 clk = ~clk;

  nonce_uart_tx #(.CLKS_PER_BIT(4)) dut4 (
    .clock(clk), .resetn(resetn), .nonceIn(nonce4), .sendValid(sendValid4),
    .ready(ready4), .tx(tx4), .done(done4)
  );

  nonce_uart_tx dut434 (
    .clock(clk), .resetn(resetn), .nonceIn(nonce434), .sendValid(sendValid434),
    .ready(ready434), .tx(tx434), .done(done434)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (done4 === 1'b1) begin
      doneCnt4++;
      lastDoneCyc = cyc;
    end
  end

  typedef struct {
    logic [31:0] word;
    logic [7:0]  b0, b1, b2, b3;
    string       name;
  } vec_t;

  function automatic logic getTx(int sel);
    return (sel == 0) ? tx4 : tx434;
  endfunction
  function automatic logic getReady(int sel);
    return (sel == 0) ? ready4 : ready434;
  endfunction
  function automatic logic getDone(int sel);
    return (sel == 0) ? done4 : done434;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at the negedge before the accepting posedge; samples every cycle of the 40 bits.
  task automatic checkFrame(input int sel, input logic [31:0] exp, input int cpb, input string name);
    int total, n, b, p;
    logic [7:0] byt;
    logic e, seen, rBad, dBad;
    total = 40 * cpb;
    rBad = 1'b0;
    dBad = 1'b0;
    for (int k = 0; k < 40; k++) begin
      b = k / 10;
      p = k % 10;
      byt = 8'(exp >> (24 - 8 * b));
      e = (p == 0) ? 1'b0 : (p == 9) ? 1'b1 : byt[p - 1];
      seen = e;
      for (int c = 0; c < cpb; c++) begin
        @(negedge clk);
        n = k * cpb + c + 1;
        if (getTx(sel) !== e) seen = getTx(sel);
        if (getReady(sel) !== (n == total)) rBad = 1'b1;
        if (getDone(sel) !== (n == total)) dBad = 1'b1;
      end
      check($sformatf("%s tx bit%0d", name, k), {31'd0, seen}, {31'd0, e});
    end
    check($sformatf("%s ready pattern", name), {31'd0, rBad}, 32'd0);
    check($sformatf("%s done pattern", name), {31'd0, dBad}, 32'd0);
  endtask

  task automatic sendOne(input int sel, input logic [31:0] word, input logic [31:0] exp,
                         input int cpb, input string name);
    if (sel == 0) begin nonce4 = word; sendValid4 = 1'b1; end
    else begin nonce434 = word; sendValid434 = 1'b1; end
    check($sformatf("%s ready at accept", name), {31'd0, getReady(sel)}, 32'd1);
    fork
      checkFrame(sel, exp, cpb, name);
      begin
        @(negedge clk);
        if (sel == 0) sendValid4 = 1'b0; else sendValid434 = 1'b0;
      end
    join
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    vec_t vecs[5];
    int d1, dcSave;
    logic bad;
    vecs[0] = '{32'hA5C3_0F81, 8'hA5, 8'hC3, 8'h0F, 8'h81, "vecA5C30F81"};
    vecs[1] = '{32'h1234_5678, 8'h12, 8'h34, 8'h56, 8'h78, "vec12345678"};
    vecs[2] = '{32'h0000_0000, 8'h00, 8'h00, 8'h00, 8'h00, "vec00000000"};
    vecs[3] = '{32'hFFFF_FFFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, "vecFFFFFFFF"};
    vecs[4] = '{32'h8001_7E3C, 8'h80, 8'h01, 8'h7E, 8'h3C, "vec80017E3C"};

    // Reset behaviour
    repeat (2) @(negedge clk);
    check("reset tx", {31'd0, tx4}, 32'd1);
    check("reset ready", {31'd0, ready4}, 32'd0);
    check("reset done", {31'd0, done4}, 32'd0);
    resetn = 1'b1;
    #1;
    check("ready before first edge", {31'd0, ready4}, 32'd0);
    @(negedge clk);
    check("ready after first edge", {31'd0, ready4}, 32'd1);
    check("ready434 after first edge", {31'd0, ready434}, 32'd1);
    check("idle tx", {31'd0, tx4}, 32'd1);

    for (int i = 0; i < 5; i++)
      sendOne(0, vecs[i].word, {vecs[i].b0, vecs[i].b1, vecs[i].b2, vecs[i].b3}, 4, vecs[i].name);
    sendValid4 = 1'b0;
    repeat (3) @(negedge clk);

    // Back-to-back words with sendValid held high
    nonce4 = 32'h0000_0000;
    sendValid4 = 1'b1;
    fork
      checkFrame(0, 32'h0000_0000, 4, "b2b first");
      begin repeat (2) @(negedge clk); nonce4 = 32'hFFFF_FFFF; end
    join
    #1;
    d1 = lastDoneCyc;
    dcSave = doneCnt4;
    fork
      checkFrame(0, 32'hFFFF_FFFF, 4, "b2b second");
      begin repeat (2) @(negedge clk); sendValid4 = 1'b0; end
    join
    #1;
    check("b2b done spacing", 32'(lastDoneCyc - d1), 32'd160);
    check("b2b second done count", 32'(doneCnt4 - dcSave), 32'd1);
    repeat (2) @(negedge clk);

    // Mid-transfer request must be ignored
    nonce4 = 32'h1234_5678;
    sendValid4 = 1'b1;
    fork
      checkFrame(0, 32'h1234_5678, 4, "ignore");
      begin
        @(negedge clk);
        sendValid4 = 1'b0;
        repeat (49) @(negedge clk);
        nonce4 = 32'hDEAD_BEEF;
        sendValid4 = 1'b1;
        @(negedge clk);
        sendValid4 = 1'b0;
      end
    join
    bad = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (tx4 !== 1'b1 || ready4 !== 1'b1) bad = 1'b1;
    end
    check("ignore stays idle", {31'd0, bad}, 32'd0);

    // Reset mid-word, during byte 2 data bit 1 (0 in A5)
    nonce4 = 32'h3C3C_A55A;
    sendValid4 = 1'b1;
    @(negedge clk);
    sendValid4 = 1'b0;
    repeat (88) @(negedge clk);
    check("pre-reset tx low", {31'd0, tx4}, 32'd0);
    dcSave = doneCnt4;
    #2 resetn = 1'b0;
    #1;
    check("async reset tx", {31'd0, tx4}, 32'd1);
    check("async reset ready", {31'd0, ready4}, 32'd0);
    check("async reset done", {31'd0, done4}, 32'd0);
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    #1;
    check("release ready still low", {31'd0, ready4}, 32'd0);
    @(negedge clk);
    check("release ready one edge later", {31'd0, ready4}, 32'd1);
    repeat (5) @(negedge clk);
    check("no done after abort", 32'(doneCnt4 - dcSave), 32'd0);
    sendOne(0, 32'h0F1E_2D3C, {8'h0F, 8'h1E, 8'h2D, 8'h3C}, 4, "after reset");
    repeat (2) @(negedge clk);

    // Default bit period
    sendOne(1, 32'h0000_0001, {8'h00, 8'h00, 8'h00, 8'h01}, 434, "cpb434");
    @(negedge clk);
    check("cpb434 idle tx", {31'd0, tx434}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
